// File: rtl/fare_pkg.sv
// fare_pkg
//   Shared definitions for the taxi fare meter: trip state encoding, default
//   price/rate constants (all money in jiao, 0.1 yuan) and a width-generic
//   saturating adder used for the running fare.
//   No ports (package).
package fare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fare_state_e;

    localparam int unsigned DEF_FARE_W      = 16;
    localparam int unsigned DEF_MILE_W      = 13;
    localparam int unsigned DEF_WAIT_W      = 10;
    localparam int unsigned DEF_START_PRICE = 100;
    localparam int unsigned DEF_FUEL        = 10;
    localparam int unsigned DEF_BASE_KM     = 3;
    localparam int unsigned DEF_TIER1_RATE  = 20;
    localparam int unsigned DEF_TIER2_RATE  = 30;
    localparam int unsigned DEF_TIER_THRESH = 200;
    localparam int unsigned DEF_WAIT_UNIT   = 5;
    localparam int unsigned DEF_WAIT_RATE   = 10;
    localparam int unsigned DEF_NIGHT_ADD   = 10;

    // a + b clamped to 2^w - 1 (w <= 32). The 33-bit sum keeps the carry so
    // w == 32 still saturates correctly.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return 32'((sum > lim) ? lim : sum);
    endfunction

    // Companion to sat_add: high when a + b does not fit in w bits.
    function automatic logic sat_ovf(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim);
    endfunction

endpackage

// File: rtl/fare_wait_timer.sv
// fare_wait_timer
//   Counts stationary minutes for the current trip and divides them by
//   WAIT_UNIT to produce a wait-charge strobe.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clear        trip start: zero the prescaler and minute counter
//     en           meter is running (ticks outside a trip are ignored)
//     wait_tick    one-cycle pulse per stationary minute
//     wait_min     saturating minute count for this trip (registered)
//     wait_charge  combinational strobe, high in the cycle whose tick
//                  completes a WAIT_UNIT group; the fare adds it on the
//                  same edge that registers the tick
module fare_wait_timer
    import fare_pkg::*;
#(
    parameter int unsigned WAIT_W    = DEF_WAIT_W,
    parameter int unsigned WAIT_UNIT = DEF_WAIT_UNIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              wait_tick,
    output logic [WAIT_W-1:0] wait_min,
    output logic              wait_charge
);

    localparam int unsigned PRE_W = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [WAIT_W-1:0] wait_min_q, wait_min_d;

    always_comb begin
        presc_d     = presc_q;
        wait_min_d  = wait_min_q;
        wait_charge = 1'b0;
        if (clear) begin
            presc_d    = '0;
            wait_min_d = '0;
        end else if (en && wait_tick) begin
            if (wait_min_q != '1) begin
                wait_min_d = wait_min_q + 1'b1;
            end
            // Reaching WAIT_UNIT is folded into the wrap: the counter never
            // holds WAIT_UNIT, it returns to 0 and charges in the same cycle.
            if (32'(presc_q) == WAIT_UNIT - 1) begin
                presc_d     = '0;
                wait_charge = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            wait_min_q <= '0;
        end else begin
            presc_q    <= presc_d;
            wait_min_q <= wait_min_d;
        end
    end

    assign wait_min = wait_min_q;

endmodule

// File: rtl/taxi_fare_meter.sv
// taxi_fare_meter
//   Trip-based fare meter between the odometer/timer front end and the
//   display driver. Flag-fall + fuel surcharge, free base distance, two-tier
//   per-km rate chosen on the running fare, waiting-time charges, saturating
//   fare with a sticky overflow flag. Money in jiao (0.1 yuan).
//   Optional build macro: NIGHT_SURCHARGE_EN adds the `night` input and the
//   NIGHT_ADD parameter (extra charge per charged km, latched at trip start).
//   Ports:
//     CLK, RST_N   clock, synchronous active-low reset
//     start        begin a trip (IDLE or DONE)
//     stop         end the running trip
//     clr          DONE -> IDLE
//     km_pulse     one-cycle pulse per km
//     wait_tick    one-cycle pulse per stationary minute
//     night        (NIGHT_SURCHARGE_EN only) night tariff request
//     fare         running / final fare
//     mileage      km this trip
//     wait_min     waiting minutes this trip
//     busy         high while the trip runs
//     fare_done    one-cycle pulse in the first DONE cycle
//     ovf          fare saturated during this trip (sticky)
//   The trip state is held in state_q for observation.
module taxi_fare_meter
    import fare_pkg::*;
#(
    parameter int unsigned FARE_W      = DEF_FARE_W,
    parameter int unsigned MILE_W      = DEF_MILE_W,
    parameter int unsigned WAIT_W      = DEF_WAIT_W,
    parameter int unsigned START_PRICE = DEF_START_PRICE,
    parameter int unsigned FUEL        = DEF_FUEL,
    parameter int unsigned BASE_KM     = DEF_BASE_KM,
    parameter int unsigned TIER1_RATE  = DEF_TIER1_RATE,
    parameter int unsigned TIER2_RATE  = DEF_TIER2_RATE,
    parameter int unsigned TIER_THRESH = DEF_TIER_THRESH,
    parameter int unsigned WAIT_UNIT   = DEF_WAIT_UNIT,
`ifdef NIGHT_SURCHARGE_EN
    parameter int unsigned NIGHT_ADD   = DEF_NIGHT_ADD,
`endif
    parameter int unsigned WAIT_RATE   = DEF_WAIT_RATE
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              stop,
    input  logic              clr,
    input  logic              km_pulse,
    input  logic              wait_tick,
`ifdef NIGHT_SURCHARGE_EN
    input  logic              night,
`endif
    output logic [FARE_W-1:0] fare,
    output logic [MILE_W-1:0] mileage,
    output logic [WAIT_W-1:0] wait_min,
    output logic              busy,
    output logic              fare_done,
    output logic              ovf
);

    localparam logic [FARE_W-1:0] TRIP_FARE = FARE_W'(START_PRICE + FUEL);

    fare_state_e       state_q, state_d;
    logic [FARE_W-1:0] fare_q, fare_d;
    logic [MILE_W-1:0] mileage_q, mileage_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trip_start;
    logic              running;
    logic              wait_charge;
    logic [31:0]       km_rate;
    logic [31:0]       charge;
`ifdef NIGHT_SURCHARGE_EN
    logic              night_q, night_d;
`endif

    assign running = (state_q == RUN);

    fare_wait_timer #(
        .WAIT_W    (WAIT_W),
        .WAIT_UNIT (WAIT_UNIT)
    ) u_wait_timer (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clear       (trip_start),
        .en          (running),
        .wait_tick   (wait_tick),
        .wait_min    (wait_min),
        .wait_charge (wait_charge)
    );

    // Next state.
    always_comb begin
        state_d    = state_q;
        trip_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    trip_start = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = RUN;
                    trip_start = 1'b1;
                end else if (clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fare, mileage and flags. Tier is chosen on the fare before this
    // cycle's charges, and km + wait charges land in one saturating add.
    always_comb begin
        fare_d    = fare_q;
        mileage_d = mileage_q;
        ovf_d     = ovf_q;
        km_rate   = (32'(fare_q) < TIER_THRESH) ? TIER1_RATE : TIER2_RATE;
        charge    = '0;
`ifdef NIGHT_SURCHARGE_EN
        night_d   = night_q;
        if (night_q) begin
            km_rate = km_rate + NIGHT_ADD;
        end
`endif
        if (trip_start) begin
            fare_d    = TRIP_FARE;
            mileage_d = '0;
            ovf_d     = 1'b0;
`ifdef NIGHT_SURCHARGE_EN
            night_d   = night;
`endif
        end else if (running) begin
            if (km_pulse) begin
                if (mileage_q != '1) begin
                    mileage_d = mileage_q + 1'b1;
                end
                if (32'(mileage_q) >= BASE_KM) begin
                    charge = km_rate;
                end
            end
            if (wait_charge) begin
                charge = charge + WAIT_RATE;
            end
            fare_d = FARE_W'(sat_add(32'(fare_q), charge, FARE_W));
            if (sat_ovf(32'(fare_q), charge, FARE_W)) begin
                ovf_d = 1'b1;
            end
        end
        busy_d = (state_d == RUN);
        done_d = running && stop;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            fare_q    <= '0;
            mileage_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef NIGHT_SURCHARGE_EN
            night_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            fare_q    <= fare_d;
            mileage_q <= mileage_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef NIGHT_SURCHARGE_EN
            night_q   <= night_d;
`endif
        end
    end

    assign fare      = fare_q;
    assign mileage   = mileage_q;
    assign busy      = busy_q;
    assign fare_done = done_q;
    assign ovf       = ovf_q;

endmodule
